bshifter32_carry_reg: RTL and testbench

- 32-bit barrel shifter used by the EX-stage ALU of the MIPS246 CPU for SLL/SRL/SRA (fixed or variable shift amount).
- Produces the shifted result plus carry (last bit shifted out) and negative (result sign) flags.
- Outputs are registered: one clock of latency, synchronous active-high reset.

---
 rtl/bshifter32_carry_reg.sv | 93 +++++++++
 tb/tb_bshifter32_carry_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bshifter32_carry_reg.sv
// rtl/bshifter32_carry_reg.sv - 32-bit log barrel shifter (SRA/SRL/SLL) with registered carry/negative flags
// Optional: define BSHIFTER_ROTATE_EN to make aluc=11 a rotate-left instead of SLL.
module bshifter32_carry_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic [31:0] c,
    output logic        carry,
    output logic        negative,
    output logic        out_valid
);

    localparam logic [1:0] OP_SRA = 2'b00;

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    logic        is_left;
    logic        fill;
    logic [31:0] src;
    logic [31:0] shr_res;
    logic [31:0] shift_res;
    logic        shift_carry;
    logic [31:0] res_next;
    logic        carry_next;

    assign is_left = aluc[1];
    assign fill    = (aluc == OP_SRA) & a[31];

    // Left shifts reuse the right-shift network on a bit-reversed operand, so
    // a[32-b] lands in the same guard position as a[b-1] does for right shifts.
    assign src = is_left ? bit_rev(a) : a;

    // Bit 0 is a guard bit that ends up holding the last bit shifted out (0 when b=0).
    logic [32:0] stg [6];
    assign stg[0] = {src, 1'b0};

    for (genvar i = 0; i < 5; i++) begin : g_stage
        localparam int S = 1 << i;
        assign stg[i+1] = b[i] ? {{S{fill}}, stg[i][32:S]} : stg[i];
    end

    assign shr_res     = stg[5][32:1];
    assign shift_res   = is_left ? bit_rev(shr_res) : shr_res;
    assign shift_carry = stg[5][0];

`ifdef BSHIFTER_ROTATE_EN
    logic [31:0] rot [6];
    assign rot[0] = a;

    for (genvar j = 0; j < 5; j++) begin : g_rot
        localparam int R = 1 << j;
        assign rot[j+1] = b[j] ? {rot[j][31-R:0], rot[j][31:32-R]} : rot[j];
    end

    always_comb begin
        res_next   = shift_res;
        carry_next = shift_carry;
        if (aluc == 2'b11) begin
            res_next   = rot[5];
            carry_next = (b != 5'd0) & rot[5][0];
        end
    end
`else
    assign res_next   = shift_res;
    assign carry_next = shift_carry;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            c         <= 32'd0;
            carry     <= 1'b0;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c        <= res_next;
                carry    <= carry_next;
                negative <= res_next[31];
            end
        end
    end

endmodule

// File: tb/tb_bshifter32_carry_reg.sv
// tb/tb_bshifter32_carry_reg.sv - self-checking bench for bshifter32_carry_reg against an arithmetic reference model
module tb_bshifter32_carry_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] c;
    logic        carry;
    logic        negative;
    logic        out_valid;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    bshifter32_carry_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .c         (c),
        .carry     (carry),
        .negative  (negative),
        .out_valid (out_valid)
    );

    function automatic logic [33:0] model(input logic [31:0] va, input logic [4:0] vb, input logic [1:0] op);
        logic [31:0] r;
        logic        cy;
        int          n;
        n  = int'(vb);
        cy = 1'b0;
        if (op == 2'b00) begin
            r = 32'($signed(va) >>> n);
            if (n != 0) cy = va[n-1];
        end else if (op == 2'b01) begin
            r = va >> n;
            if (n != 0) cy = va[n-1];
        end else begin
`ifdef BSHIFTER_ROTATE_EN
            if (op == 2'b11) begin
                r = (n == 0) ? va : ((va << n) | (va >> (32 - n)));
                if (n != 0) cy = r[0];
            end else begin
                r = va << n;
                if (n != 0) cy = va[32-n];
            end
`else
            r = va << n;
            if (n != 0) cy = va[32-n];
`endif
        end
        return {r[31], cy, r};
    endfunction

    task automatic drive(input logic v, input logic [31:0] va, input logic [4:0] vb, input logic [1:0] op);
        in_valid = v;
        a        = va;
        b        = vb;
        aluc     = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [34:0] exp;
        rst = 1'b1;
        exp = 35'd0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h12345678, 5'd4, 2'b01);
            tests_run++;
            if ({out_valid, negative, carry, c} !== exp) begin
                fails++;
                $display("FAIL reset cycle %0d: got v=%b n=%b cy=%b c=%h, want all zero", k, out_valid, negative, carry, c);
            end
        end
        rst = 1'b0;
        drive(1'b1, 32'h80000001, 5'd1, 2'b01);
        exp = {1'b1, 1'b0, 1'b1, 32'h40000000};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL first_after_reset: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
    endtask

    task automatic test_zero_shift();
        logic [1:0] ops [4];
        logic [34:0] exp;
        ops = '{2'b01, 2'b00, 2'b10, 2'b11};
        exp = {1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hFFFFFFFF, 5'd0, ops[k]);
            tests_run++;
            if ({out_valid, negative, carry, c} !== exp) begin
                fails++;
                $display("FAIL zero_shift aluc=%b: got %h, want %h", ops[k], {out_valid, negative, carry, c}, exp);
            end
        end
    endtask

    task automatic test_right();
        logic [34:0] exp;
        drive(1'b1, 32'h80000001, 5'd1, 2'b01);
        exp = {1'b1, 1'b0, 1'b1, 32'h40000000};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL srl_1: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
        drive(1'b1, 32'h80000001, 5'd1, 2'b00);
        exp = {1'b1, 1'b1, 1'b1, 32'hC0000000};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL sra_1: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
    endtask

    task automatic test_left();
        logic [34:0] exp;
        drive(1'b1, 32'h40000001, 5'd2, 2'b10);
        exp = {1'b1, 1'b0, 1'b1, 32'h00000004};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL sll_2: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
        drive(1'b1, 32'h40000001, 5'd1, 2'b10);
        exp = {1'b1, 1'b1, 1'b0, 32'h80000002};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL sll_1: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
    endtask

    task automatic test_max_shift();
        logic [34:0] exp;
        drive(1'b1, 32'h80000000, 5'd31, 2'b00);
        exp = {1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL sra_31: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
        drive(1'b1, 32'h80000000, 5'd31, 2'b01);
        exp = {1'b1, 1'b0, 1'b0, 32'h00000001};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL srl_31: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
        drive(1'b1, 32'h00000003, 5'd31, 2'b10);
        exp = {1'b1, 1'b1, 1'b1, 32'h80000000};
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL sll_31: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
    endtask

    task automatic test_hold_rotate();
        logic [34:0] exp;
        drive(1'b1, 32'h80000001, 5'd1, 2'b11);
`ifdef BSHIFTER_ROTATE_EN
        exp = {1'b1, 1'b0, 1'b1, 32'h00000003};
`else
        exp = {1'b1, 1'b0, 1'b1, 32'h00000002};
`endif
        tests_run++;
        if ({out_valid, negative, carry, c} !== exp) begin
            fails++;
            $display("FAIL aluc11: got %h, want %h", {out_valid, negative, carry, c}, exp);
        end
        exp[34] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'hDEADBEEF, 5'd7, 2'b00);
            tests_run++;
            if ({out_valid, negative, carry, c} !== exp) begin
                fails++;
                $display("FAIL hold cycle %0d: got %h, want %h", k, {out_valid, negative, carry, c}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] held;
        logic [33:0] m;
        logic        v;
        logic [31:0] ra;
        logic [4:0]  rb;
        logic [1:0]  rop;
        drive(1'b1, 32'h0, 5'd0, 2'b01);
        held = 34'd0;
        for (int k = 0; k < 400; k++) begin
            v   = ($urandom_range(0, 3) != 0);
            ra  = $urandom;
            rb  = 5'($urandom_range(0, 31));
            rop = 2'($urandom_range(0, 3));
            drive(v, ra, rb, rop);
            if (v) begin
                m    = model(ra, rb, rop);
                held = m;
            end
            tests_run++;
            if ({out_valid, negative, carry, c} !== {v, held}) begin
                fails++;
                $display("FAIL random #%0d a=%h b=%0d aluc=%b v=%b: got %h, want %h",
                         k, ra, rb, rop, v, {out_valid, negative, carry, c}, {v, held});
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        drive(1'b1, 32'hFFFF0000, 5'd3, 2'b00);
        rst = 1'b1;
        drive(1'b1, 32'hFFFF0000, 5'd3, 2'b00);
        rst = 1'b0;
        tests_run++;
        if ({out_valid, negative, carry, c} !== 35'd0) begin
            fails++;
            $display("FAIL reset_priority: got %h, want 0", {out_valid, negative, carry, c});
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = 32'd0;
        b        = 5'd0;
        aluc     = 2'b00;
        @(negedge clk);
        test_reset();
        test_zero_shift();
        test_right();
        test_left();
        test_max_shift();
        test_hold_rotate();
        test_random();
        test_back_to_back_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
